// File: rtl/door_seq.sv
// Push-button door motor sequencer: debounced PRESS, open/hold/close cycle,
// obstruction reversal, direction-change dead-time and latched fault.
module door_seq #(
  parameter int CW       = 8,
  parameter int DEB_CYC  = 4,
  parameter int HOLD_CYC = 20,
  parameter int MOT_TO   = 50,
  parameter int DEAD_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PRESS,
  input  logic       LIM_OPEN,
  input  logic       LIM_CLOSED,
  input  logic       OBSTRUCT,
  output logic       M_CW,
  output logic       M_ACW,
  output logic       DOOR_OPEN,
  output logic       FAULT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_OPENING = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSING = 3'd3,
    S_STOPPED = 3'd4,
    S_DEAD    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  localparam logic [CW:0] DEB_L  = (CW+1)'(DEB_CYC);
  localparam logic [CW:0] HOLD_L = (CW+1)'(HOLD_CYC);
  localparam logic [CW:0] MOT_L  = (CW+1)'(MOT_TO);
  localparam logic [CW:0] DEAD_L = (CW+1)'(DEAD_CYC);
  localparam logic [CW:0] ONE_L  = (CW+1)'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic          deb_lvl_q, deb_lvl_d;
  logic          evt_q, evt_d;
  logic          dir_close_q, dir_close_d;
  logic          tgt_close_q, tgt_close_d;

  logic [CW:0]   tmr_inc;
  logic [CW:0]   deb_inc;
  logic          tmr_clr;
  logic          tmr_frz;

  assign tmr_inc = {1'b0, tmr_q} + ONE_L;
  assign deb_inc = {1'b0, deb_cnt_q} + ONE_L;

  // Debounce: flip the level after DEB_CYC consecutive opposite samples;
  // the press event is registered on the rising flip only.
  always_comb begin
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    evt_d     = 1'b0;
    if (PRESS != deb_lvl_q) begin
      if (deb_inc >= DEB_L) begin
        deb_lvl_d = PRESS;
        evt_d     = PRESS;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_close_d = dir_close_q;
    tgt_close_d = tgt_close_q;
    tmr_clr     = 1'b0;
    tmr_frz     = 1'b0;
    unique case (state_q)
      S_CLOSED: begin
        if (evt_q) state_d = S_OPENING;
      end
      S_OPENING: begin
        if (LIM_OPEN) begin
          state_d = S_OPEN;
        end else if (tmr_inc >= MOT_L) begin
          state_d = S_FAULT;
        end else if (evt_q) begin
          state_d     = S_STOPPED;
          dir_close_d = 1'b0;
        end
      end
      S_OPEN: begin
        if (OBSTRUCT) begin
          tmr_clr = 1'b1;
        end else if (evt_q || (tmr_inc >= HOLD_L)) begin
          state_d = S_CLOSING;
        end
      end
      S_CLOSING: begin
        if (OBSTRUCT) begin
          state_d     = S_DEAD;
          tgt_close_d = 1'b0;
        end else if (LIM_CLOSED) begin
          state_d = S_CLOSED;
        end else if (tmr_inc >= MOT_L) begin
          state_d = S_FAULT;
        end else if (evt_q) begin
          state_d     = S_STOPPED;
          dir_close_d = 1'b1;
        end
      end
      S_STOPPED: begin
        tmr_frz = 1'b1;
        if (evt_q) begin
          state_d     = S_DEAD;
          tgt_close_d = ~dir_close_q;
        end
      end
      S_DEAD: begin
        if (tmr_inc >= DEAD_L) state_d = tgt_close_q ? S_CLOSING : S_OPENING;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // Contradictory limit switches override everything else.
    if (LIM_OPEN && LIM_CLOSED) state_d = S_FAULT;

    if (state_d != state_q || tmr_clr) begin
      tmr_d = '0;
    end else if (tmr_frz || (&tmr_q)) begin
      tmr_d = tmr_q;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_CLOSED;
      tmr_q       <= '0;
      deb_cnt_q   <= '0;
      deb_lvl_q   <= 1'b0;
      evt_q       <= 1'b0;
      dir_close_q <= 1'b0;
      tgt_close_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_lvl_q   <= deb_lvl_d;
      evt_q       <= evt_d;
      dir_close_q <= dir_close_d;
      tgt_close_q <= tgt_close_d;
    end
  end

  assign M_CW      = (state_q == S_OPENING);
  assign M_ACW     = (state_q == S_CLOSING);
  assign DOOR_OPEN = (state_q == S_OPEN);
  assign FAULT     = (state_q == S_FAULT);
  assign STATE     = state_q;

endmodule

// File: tb/tb_door_seq.sv
// Self-checking bench for door_seq: per-cycle expected state/outputs are
// queued before each edge and popped for comparison just after it.
module tb_door_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PRESS;
  logic       LIM_OPEN;
  logic       LIM_CLOSED;
  logic       OBSTRUCT;
  logic       M_CW;
  logic       M_ACW;
  logic       DOOR_OPEN;
  logic       FAULT;
  logic [2:0] STATE;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] sb_q[$];

  door_seq #(
    .CW(8), .DEB_CYC(4), .HOLD_CYC(20), .MOT_TO(50), .DEAD_CYC(2)
  ) dut (
    .CLK(CLK), .RST(RST), .PRESS(PRESS), .LIM_OPEN(LIM_OPEN),
    .LIM_CLOSED(LIM_CLOSED), .OBSTRUCT(OBSTRUCT), .M_CW(M_CW),
    .M_ACW(M_ACW), .DOOR_OPEN(DOOR_OPEN), .FAULT(FAULT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Expected output vector {STATE, M_CW, M_ACW, DOOR_OPEN, FAULT} for a state.
  function automatic logic [6:0] exp_vec(input int st);
    logic [2:0] s;
    s = 3'(st);
    return {s, (st == 1), (st == 3), (st == 2), (st == 6)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; PRESS = 1'b0; LIM_OPEN = 1'b0; LIM_CLOSED = 1'b0; OBSTRUCT = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] got, want;
    RST = 1'b0; PRESS = 1'b1; LIM_OPEN = 1'b0; LIM_CLOSED = 1'b0; OBSTRUCT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(exp_vec(0));
      tick();
      want = sb_q.pop_front();
      got  = {STATE, M_CW, M_ACW, DOOR_OPEN, FAULT};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset c%0d got=%b want=%b", i, got, want);
      end
    end
    PRESS = 1'b0;
    RST   = 1'b1;
  endtask

  // Press for 6 samples; LIM_OPEN from the 11th edge.
  task automatic test_open();
    logic [6:0] got, want;
    int j, st;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      j = i + 1;
      PRESS    = (i < 6);
      LIM_OPEN = (i >= 10);
      st = (j < 5) ? 0 : (j < 11) ? 1 : 2;
      sb_q.push_back(exp_vec(st));
      tick();
      want = sb_q.pop_front();
      got  = {STATE, M_CW, M_ACW, DOOR_OPEN, FAULT};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL open e%0d got=%b want=%b", j, got, want);
      end
    end
  endtask

  // Continues from test_open, which entered OPEN on its last edge.
  task automatic test_autoclose();
    logic [6:0] got, want;
    int j, st;
    for (int i = 0; i < 26; i++) begin
      j = i + 1;
      PRESS      = 1'b0;
      LIM_OPEN   = 1'b0;
      LIM_CLOSED = (j >= 25);
      st = (j < 20) ? 2 : (j < 25) ? 3 : 0;
      sb_q.push_back(exp_vec(st));
      tick();
      want = sb_q.pop_front();
      got  = {STATE, M_CW, M_ACW, DOOR_OPEN, FAULT};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL autoclose e%0d got=%b want=%b", j, got, want);
      end
    end
    LIM_CLOSED = 1'b0;
  endtask

  task automatic test_obstruct();
    logic [6:0] got, want;
    int j, st;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      j = i + 1;
      PRESS    = (i < 4) || (i >= 8 && i < 12);
      LIM_OPEN = (i == 6) || (i == 17);
      OBSTRUCT = (i == 14);
      st = (j < 5) ? 0 : (j < 7) ? 1 : (j < 13) ? 2 : (j < 15) ? 3 :
           (j < 17) ? 5 : (j < 18) ? 1 : 2;
      sb_q.push_back(exp_vec(st));
      tick();
      want = sb_q.pop_front();
      got  = {STATE, M_CW, M_ACW, DOOR_OPEN, FAULT};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL obstruct e%0d got=%b want=%b", j, got, want);
      end
    end
    LIM_OPEN = 1'b0; OBSTRUCT = 1'b0;
  endtask

  // 3-sample glitch ignored, then open, stop, reverse through DEAD to CLOSING.
  task automatic test_glitch_stop();
    logic [6:0] got, want;
    int j, st;
    do_reset();
    for (int i = 0; i < 31; i++) begin
      j = i + 1;
      PRESS = (i < 3) || (i >= 7 && i <= 10) || (i >= 15 && i <= 18) ||
              (i >= 23 && i <= 26);
      st = (j < 12) ? 0 : (j < 20) ? 1 : (j < 28) ? 4 : (j < 30) ? 5 : 3;
      sb_q.push_back(exp_vec(st));
      tick();
      want = sb_q.pop_front();
      got  = {STATE, M_CW, M_ACW, DOOR_OPEN, FAULT};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL glitch_stop e%0d got=%b want=%b", j, got, want);
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] got, want;
    int j, st;
    do_reset();
    for (int i = 0; i < 66; i++) begin
      j = i + 1;
      PRESS = (i < 4) || (i >= 58 && i < 62);
      st = (j < 5) ? 0 : (j < 55) ? 1 : 6;
      sb_q.push_back(exp_vec(st));
      tick();
      want = sb_q.pop_front();
      got  = {STATE, M_CW, M_ACW, DOOR_OPEN, FAULT};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL timeout e%0d got=%b want=%b", j, got, want);
      end
    end
    // Asynchronous reset between clock edges.
    #2;
    sb_q.push_back(exp_vec(0));
    RST = 1'b0;
    #1;
    want = sb_q.pop_front();
    got  = {STATE, M_CW, M_ACW, DOOR_OPEN, FAULT};
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL async_reset got=%b want=%b", got, want);
    end
    RST = 1'b1;
  endtask

  task automatic test_lim_conflict();
    logic [6:0] got, want;
    int j, st;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      LIM_OPEN   = (i == 0);
      LIM_CLOSED = (i == 0);
      sb_q.push_back(exp_vec(6));
      tick();
      want = sb_q.pop_front();
      got  = {STATE, M_CW, M_ACW, DOOR_OPEN, FAULT};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL lim_both c%0d got=%b want=%b", i, got, want);
      end
    end
    do_reset();
    for (int i = 0; i < 14; i++) begin
      j = i + 1;
      PRESS    = (i < 4) || (i >= 8 && i < 12);
      LIM_OPEN = (i == 12);
      st = (j < 5) ? 0 : (j < 13) ? 1 : 2;
      sb_q.push_back(exp_vec(st));
      tick();
      want = sb_q.pop_front();
      got  = {STATE, M_CW, M_ACW, DOOR_OPEN, FAULT};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL lim_vs_press e%0d got=%b want=%b", j, got, want);
      end
    end
    LIM_OPEN = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_open();
    test_autoclose();
    test_obstruct();
    test_glitch_stop();
    test_timeout();
    test_lim_conflict();
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
